// File: rtl/mppt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mppt_pkg
//  Description : Shared types and default constants for the perturb-and-observe
//                MPPT duty controller (FSM state, sample/duty/power widths,
//                default step and clamp values).
//  Revision    : 1.0 - initial release
// ============================================================================
package mppt_pkg;

    // Tracking iteration sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_MULT   = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    typedef logic [7:0]  sample_t;
    typedef logic [7:0]  duty_t;
    typedef logic [15:0] power_t;

    localparam int unsigned C_STEP_DEF      = 2;
    localparam int unsigned C_DUTY_MIN_DEF  = 16;
    localparam int unsigned C_DUTY_MAX_DEF  = 240;
    localparam int unsigned C_DUTY_INIT_DEF = 128;

    // Full-precision panel power from an 8-bit voltage and current sample
    function automatic power_t power_of(input sample_t v, input sample_t i);
        return power_t'({8'd0, v} * {8'd0, i});
    endfunction

endpackage
`default_nettype wire

// File: rtl/mppt_po_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mppt_po_ctrl_if
//  Description : Sample/command bundle between the sampling front end (master)
//                and the MPPT duty controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mppt_po_ctrl_if;
    import mppt_pkg::*;

    logic    ena;
    logic    start;
    sample_t v_in;
    sample_t i_in;
    duty_t   duty;
    logic    duty_valid;
    logic    busy;
    logic    dir_up;

    modport master (
        output ena, start, v_in, i_in,
        input  duty, duty_valid, busy, dir_up
    );

    modport slave (
        input  ena, start, v_in, i_in,
        output duty, duty_valid, busy, dir_up
    );

endinterface
`default_nettype wire

// File: rtl/mppt_duty_step.sv
`default_nettype none
// ============================================================================
//  Module      : mppt_duty_step
//  Description : Combinational duty perturbation. Moves the duty by STEP in
//                the requested direction; a step that reaches or would cross
//                a clamp lands on the clamp and reverses the direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module mppt_duty_step
    import mppt_pkg::*;
#(
    parameter int unsigned STEP     = C_STEP_DEF,
    parameter int unsigned DUTY_MIN = C_DUTY_MIN_DEF,
    parameter int unsigned DUTY_MAX = C_DUTY_MAX_DEF
) (
    input  duty_t i_duty,
    input  logic  i_dir_up,
    output duty_t o_duty,
    output logic  o_dir_up
);

    // Two guard bits keep the upward sum and the lower limit free of wrap
    localparam logic [9:0] c_step = 10'(STEP);
    localparam logic [9:0] c_min  = 10'(DUTY_MIN);
    localparam logic [9:0] c_max  = 10'(DUTY_MAX);

    logic [9:0] w_duty_ext;
    logic [9:0] w_up_sum;
    logic [9:0] w_down_lim;

    assign w_duty_ext = {2'b00, i_duty};
    assign w_up_sum   = w_duty_ext + c_step;
    assign w_down_lim = c_min + c_step;

    // Saturating step with direction reversal at either clamp
    always_comb begin
        o_duty   = i_duty;
        o_dir_up = i_dir_up;
        if (i_dir_up) begin
            if (w_up_sum >= c_max) begin
                o_duty   = c_max[7:0];
                o_dir_up = 1'b0;
            end else begin
                o_duty   = w_up_sum[7:0];
            end
        end else begin
            // duty - STEP <= DUTY_MIN, evaluated without underflow
            if (w_duty_ext <= w_down_lim) begin
                o_duty   = c_min[7:0];
                o_dir_up = 1'b1;
            end else begin
                o_duty   = i_duty - c_step[7:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mppt_po_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mppt_po_ctrl
//  Description : Perturb-and-observe MPPT controller. Each accepted start tick
//                latches V/I, forms P = V*I, compares with the previous power
//                and steps the converter duty, reversing on power drop or on
//                reaching a clamp. New duty and duty_valid appear 3 edges
//                after the accepted start.
//  Options     : MPPT_SOFTSTART_EN - reset to DUTY_MIN and ramp +1 per start
//                tick up to DUTY_INIT before tracking begins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mppt_po_ctrl
    import mppt_pkg::*;
#(
    parameter int unsigned STEP      = C_STEP_DEF,
    parameter int unsigned DUTY_MIN  = C_DUTY_MIN_DEF,
    parameter int unsigned DUTY_MAX  = C_DUTY_MAX_DEF,
    parameter int unsigned DUTY_INIT = C_DUTY_INIT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mppt_po_ctrl_if.slave  bus
);

`ifdef MPPT_SOFTSTART_EN
    localparam duty_t c_duty_reset = duty_t'(DUTY_MIN);
`else
    localparam duty_t c_duty_reset = duty_t'(DUTY_INIT);
`endif

    state_t  r_state;
    state_t  w_state_next;
    logic    w_capture;
    logic    w_mult;
    logic    w_decide;

    sample_t r_v;
    sample_t r_i;
    power_t  r_p_new;
    power_t  r_p_prev;
    logic    r_first_done;
    duty_t   r_duty;
    logic    r_dir_up;
    logic    r_duty_valid;

    logic    w_dir_track;
    duty_t   w_duty_step;
    logic    w_dir_step;
    logic    w_ramping;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-state datapath strobes; ena low aborts any iteration
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_mult       = 1'b0;
        w_decide     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && bus.ena) begin
                    w_state_next = ST_SAMPLE;
                    w_capture    = 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_state_next = bus.ena ? ST_MULT : ST_IDLE;
            end
            ST_MULT: begin
                w_state_next = bus.ena ? ST_DECIDE : ST_IDLE;
                w_mult       = bus.ena;
            end
            ST_DECIDE: begin
                w_state_next = ST_IDLE;
                w_decide     = bus.ena;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // First iteration keeps the direction; afterwards a power drop reverses it
    assign w_dir_track = (r_first_done && (r_p_new < r_p_prev)) ? ~r_dir_up : r_dir_up;

    mppt_duty_step #(
        .STEP     (STEP),
        .DUTY_MIN (DUTY_MIN),
        .DUTY_MAX (DUTY_MAX)
    ) u_duty_step (
        .i_duty   (r_duty),
        .i_dir_up (w_dir_track),
        .o_duty   (w_duty_step),
        .o_dir_up (w_dir_step)
    );

`ifdef MPPT_SOFTSTART_EN
    logic r_ramp_done;

    // Soft-start ramp completes once the duty reaches DUTY_INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp_done <= (DUTY_MIN >= DUTY_INIT);
        end else if (w_decide && !r_ramp_done &&
                     (({1'b0, r_duty} + 9'd1) >= 9'(DUTY_INIT))) begin
            r_ramp_done <= 1'b1;
        end
    end

    assign w_ramping = ~r_ramp_done;
`else
    assign w_ramping = 1'b0;
`endif

    // Sample capture, power product and duty/direction update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v          <= '0;
            r_i          <= '0;
            r_p_new      <= '0;
            r_p_prev     <= '0;
            r_first_done <= 1'b0;
            r_duty       <= c_duty_reset;
            r_dir_up     <= 1'b1;
            r_duty_valid <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            if (w_capture) begin
                r_v <= bus.v_in;
                r_i <= bus.i_in;
            end
            if (w_mult) begin
                r_p_new <= power_of(r_v, r_i);
            end
            if (w_decide) begin
                r_duty_valid <= 1'b1;
                if (w_ramping) begin
                    // Soft-start: plain +1 ramp, tracking state untouched
                    r_duty <= r_duty + 8'd1;
                end else begin
                    r_duty       <= w_duty_step;
                    r_dir_up     <= w_dir_step;
                    r_p_prev     <= r_p_new;
                    r_first_done <= 1'b1;
                end
            end
        end
    end

    assign bus.duty       = r_duty;
    assign bus.duty_valid = r_duty_valid;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.dir_up     = r_dir_up;

endmodule
`default_nettype wire

// File: tb/tb_mppt_po_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mppt_po_ctrl
//  Description : Self-checking bench for mppt_po_ctrl. A behavioural P&O model
//                pushes the expected duty/direction for every accepted start;
//                a monitor pops and compares on each duty_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mppt_po_ctrl;
    import mppt_pkg::*;

    localparam int STEP  = 2;
    localparam int DMIN  = 16;
    localparam int DMAX  = 240;
    localparam int DINIT = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mppt_po_ctrl_if bus ();
    mppt_po_ctrl_if bus2 ();

    mppt_po_ctrl #(
        .STEP(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_INIT(DINIT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Second instance starting one below the upper clamp
    mppt_po_ctrl #(
        .STEP(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_INIT(239)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        int duty;
        int dir;
    } exp_t;

    exp_t q_exp[$];
    exp_t r_exp;

    int n_checks  = 0;
    int n_errors  = 0;
    int dv_count  = 0;
    int seen_max  = 0;
    int seen_min  = 255;

    int m_duty, m_dir, m_pprev, m_first, m_ramp_done;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
`ifdef MPPT_SOFTSTART_EN
        m_duty      = DMIN;
        m_ramp_done = 0;
`else
        m_duty      = DINIT;
        m_ramp_done = 1;
`endif
        m_dir   = 1;
        m_pprev = 0;
        m_first = 0;
    endtask

    // Reference P&O step for one accepted start with power p
    task automatic model_iter(input int p);
        exp_t e;
        if (!m_ramp_done) begin
            m_duty++;
            if (m_duty >= DINIT) m_ramp_done = 1;
        end else begin
            if (m_first != 0 && p < m_pprev) m_dir = (m_dir != 0) ? 0 : 1;
            m_first = 1;
            m_pprev = p;
            if (m_dir != 0) begin
                if (m_duty + STEP >= DMAX) begin
                    m_duty = DMAX;
                    m_dir  = 0;
                end else begin
                    m_duty = m_duty + STEP;
                end
            end else begin
                if (m_duty - STEP <= DMIN) begin
                    m_duty = DMIN;
                    m_dir  = 1;
                end else begin
                    m_duty = m_duty - STEP;
                end
            end
        end
        e.duty = m_duty;
        e.dir  = m_dir;
        q_exp.push_back(e);
    endtask

    // Scoreboard consumer: every duty_valid must match the oldest expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.duty_valid === 1'b1) begin
            dv_count++;
            if (int'(bus.duty) > seen_max) seen_max = int'(bus.duty);
            if (int'(bus.duty) < seen_min) seen_min = int'(bus.duty);
            if (q_exp.size() == 0) begin
                check("dv_unexpected", 1, 0);
            end else begin
                r_exp = q_exp.pop_front();
                check("sb_duty", bus.duty, r_exp.duty);
                check("sb_dir", bus.dir_up, r_exp.dir);
            end
        end
    end

    // One start pulse with latency/busy checks around it
    task automatic run_iter(input int v, input int i);
        @(negedge clk);
        bus.start = 1'b1;
        bus.v_in  = 8'(v);
        bus.i_in  = 8'(i);
        model_iter(v * i);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("lat1_busy", bus.busy, 1);
        check("lat1_dv", bus.duty_valid, 0);
        @(posedge clk); #1;
        check("lat2_dv", bus.duty_valid, 0);
        @(posedge clk); #1;
        check("lat3_dv", bus.duty_valid, 1);
        check("lat3_busy", bus.busy, 0);
    endtask

    // Start accepted, then an abort (ena drop or reset) once in MULT
    task automatic start_to_mult(input int v, input int i);
        @(negedge clk);
        bus.start = 1'b1;
        bus.v_in  = 8'(v);
        bus.i_in  = 8'(i);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_before;
        int dv_before;

        bus.ena   = 1'b1;
        bus.start = 1'b0;
        bus.v_in  = '0;
        bus.i_in  = '0;
        bus2.ena   = 1'b1;
        bus2.start = 1'b0;
        bus2.v_in  = '0;
        bus2.i_in  = '0;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_duty", bus.duty, m_duty);
        check("rst_dv", bus.duty_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_dir", bus.dir_up, 1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MPPT_SOFTSTART_EN
        dv_before = dv_count;
        repeat (112) run_iter(50, 50);
        check("ramp_dv_count", dv_count - dv_before, 112);
        check("ramp_duty", bus.duty, 128);
`else
        // Clamp reached from 239 on the first step, then tracking downward
        @(negedge clk);
        bus2.start = 1'b1; bus2.v_in = 8'd10; bus2.i_in = 8'd10;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        check("clamp_dv", bus2.duty_valid, 1);
        check("clamp_duty", bus2.duty, 240);
        check("clamp_dir", bus2.dir_up, 0);
        @(negedge clk);
        bus2.start = 1'b1; bus2.v_in = 8'd20; bus2.i_in = 8'd20;
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        check("clamp_next_duty", bus2.duty, 238);
        check("clamp_next_dir", bus2.dir_up, 0);
`endif

        // Reference sequence: 5000 -> 5500 -> 4000
        run_iter(100, 50);
        check("p1_duty", bus.duty, 130);
        check("p1_dir", bus.dir_up, 1);
        run_iter(110, 50);
        check("p2_duty", bus.duty, 132);
        check("p2_dir", bus.dir_up, 1);
        run_iter(100, 40);
        check("p3_duty", bus.duty, 130);
        check("p3_dir", bus.dir_up, 0);

        // start held for 8 cycles: exactly two iterations
        @(negedge clk);
        bus.start = 1'b1;
        bus.v_in  = 8'd100;
        bus.i_in  = 8'd60;
        model_iter(6000);
        model_iter(6000);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("hold_dv", bus.duty_valid, (k == 3 || k == 7) ? 1 : 0);
        end
        bus.start = 1'b0;

        // ena dropped in MULT
        d_before  = int'(bus.duty);
        dv_before = dv_count;
        start_to_mult(120, 60);
        @(negedge clk);
        bus.ena = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        bus.ena = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_dv", dv_count, dv_before);
        check("abort_duty", bus.duty, d_before);
        run_iter(120, 60);

        // Reset asserted mid-iteration
        dv_before = dv_count;
        start_to_mult(90, 90);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_duty", bus.duty, m_duty);
        check("midrst_dir", bus.dir_up, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_dv", dv_count, dv_before);

        // Constant power sweeps the duty across both clamps
        repeat (300) run_iter(100, 100);
        check("hit_max", seen_max, DMAX);
        check("hit_min", seen_min, DMIN);

        // Assorted samples
        repeat (20) run_iter(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        repeat (4) @(negedge clk);
        check("sb_drained", q_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mppt_po_ctrl.md
MPPT_PO_CTRL -- requirements
Module: mppt_po_ctrl

Interface
REQ-001 Parameter STEP, default 2: duty perturbation step per tracking iteration.
REQ-002 Parameter DUTY_MIN, default 16: lower duty clamp.
REQ-003 Parameter DUTY_MAX, default 240: upper duty clamp.
REQ-004 Parameter DUTY_INIT, default 128: duty value after reset.
REQ-005 Port clk, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port ena, input, 1: block enable.
REQ-008 Port start, input, 1: single-cycle sample tick requesting one tracking iteration.
REQ-009 Port v_in, input, 8: panel voltage sample, unsigned.
REQ-010 Port i_in, input, 8: panel current sample, unsigned.
REQ-011 Port duty, output, 8: converter PWM duty command.
REQ-012 Port duty_valid, output, 1: one-cycle pulse when duty has been updated.
REQ-013 Port busy, output, 1: high while an iteration is in progress.
REQ-014 Port dir_up, output, 1: current perturbation direction; 1 means increasing duty.

Function
REQ-015 FSM states: IDLE, SAMPLE, MULT, DECIDE; transitions IDLE->SAMPLE->MULT->DECIDE->IDLE, one state per cycle.
REQ-016 IDLE->SAMPLE SHALL occur only when start=1 and ena=1; v_in and i_in SHALL be latched on that edge.
REQ-017 MULT SHALL register p_new = v*i as a 16-bit unsigned product; no truncation.
REQ-018 DECIDE: if first_done=0, keep dir_up and set first_done=1; else if p_new<p_prev, invert dir_up; else (p_new>=p_prev) keep dir_up.
REQ-019 DECIDE: duty SHALL step by STEP in the resulting direction, saturating at DUTY_MIN/DUTY_MAX; p_prev SHALL be loaded with p_new.
REQ-020 A step that reaches or would cross a clamp SHALL set duty to the clamp and invert dir_up in the same cycle.
REQ-021 duty_valid SHALL pulse for the single cycle after DECIDE, so start at edge N gives the new duty and duty_valid=1 at edge N+3.
REQ-022 busy SHALL be 1 in SAMPLE, MULT and DECIDE, and 0 in IDLE.
REQ-023 start asserted while busy=1 SHALL be ignored, not queued.
REQ-024 ena=0 in any non-IDLE state SHALL abort to IDLE on the next edge, with duty, dir_up and p_prev unchanged and no duty_valid.
REQ-025 A start coinciding with duty_valid SHALL be accepted, since the FSM is already in IDLE.

Reset
REQ-026 While rst_n=0, the outputs SHALL be: state=IDLE, duty=DUTY_INIT, duty_valid=0, busy=0, dir_up=1.
REQ-027 While rst_n=0, the internal state SHALL be: p_prev=0, first_done=0.
REQ-028 Reset asserted mid-iteration SHALL discard the iteration immediately, with no duty_valid.

Configuration
REQ-029 With MPPT_SOFTSTART_EN defined, reset SHALL set duty to DUTY_MIN instead of DUTY_INIT.
REQ-030 With MPPT_SOFTSTART_EN defined, duty SHALL then ramp +1 per start tick up to DUTY_INIT with no tracking.
REQ-031 With MPPT_SOFTSTART_EN defined, duty_valid SHALL pulse each ramp step, and P&O SHALL begin on the first start after duty reaches DUTY_INIT.
REQ-032 Without MPPT_SOFTSTART_EN, tracking SHALL start from DUTY_INIT on the first start tick.

Structure
REQ-033 A shared package mppt_pkg SHALL hold the FSM state enum, the 8-bit duty and 16-bit power typedefs, and the default clamp/step constants.
REQ-034 One sub-module, mppt_duty_step, SHALL perform the combinational saturate-and-reverse step computation (duty, dir, STEP -> next duty, next dir).

Verification
REQ-035 Reset, then start with v=100, i=50 -> duty_valid at start+3 cycles, duty=130, dir_up=1, p_prev=5000.
REQ-036 Second start with v=110, i=50 (P=5500>5000) -> duty=132, dir_up=1; third start with v=100, i=40 (P=4000) -> dir_up=0, duty=130.
REQ-037 Starting from duty=239, dir_up=1, an increasing-power iteration -> duty=240, dir_up=0; the next iteration steps duty to 238.
REQ-038 start held high for 8 cycles -> exactly two iterations, with duty_valid pulsing at cycles 3 and 7.
REQ-039 ena dropped during MULT -> FSM returns to IDLE, no duty_valid, duty unchanged; a later start completes normally.
REQ-040 With MPPT_SOFTSTART_EN defined: after reset duty=16, and after 112 start ticks duty=128 with 112 duty_valid pulses; the next tick performs P&O.
